// File: rtl/bcd_addsub_seq.sv
// Sequential packed-BCD adder/subtractor: one digit per clock, least significant digit first.
// Optional invalid-digit detection is enabled by defining BCD_ADDSUB_INVALID_DIGIT_EN;
// without it o_err is tied to 0.
module bcd_addsub_seq #(
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic [NUM_DIGITS*4-1:0] i_num_a,
    input  logic [NUM_DIGITS*4-1:0] i_num_b,
    input  logic                    i_carry,
    output logic [NUM_DIGITS*4-1:0] o_num,
    output logic                    o_carry,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int unsigned W    = NUM_DIGITS * 4;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [W-1:0]    res_q, res_d, num_q, num_d;
    logic            mode_q, mode_d, carry_q, carry_d, ocarry_q, ocarry_d;

    logic [3:0] a_dig, b_dig, b_op, sum_dig;
    logic [4:0] raw, raw_adj;
    logic       dig_carry;
    logic       finish;

    // One BCD digit step on the digit selected by idx_q
    always_comb begin
        a_dig     = a_q[4*idx_q +: 4];
        b_dig     = b_q[4*idx_q +: 4];
        // Subtraction adds the nines' complement of B
        b_op      = mode_q ? (4'd9 - b_dig) : b_dig;
        raw       = {1'b0, a_dig} + {1'b0, b_op} + {4'b0000, carry_q};
        raw_adj   = raw + 5'd6;
        dig_carry = (raw > 5'd9);
        sum_dig   = dig_carry ? raw_adj[3:0] : raw[3:0];
    end

    assign finish = (state_q == StRun) && (idx_q == LastIdx);

    // Next-state logic: accept, step through digits, publish result on completion
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        res_d    = res_q;
        num_d    = num_q;
        ocarry_d = ocarry_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    state_d = StRun;
                    idx_d   = '0;
                    a_d     = i_num_a;
                    b_d     = i_num_b;
                    mode_d  = i_mode;
                    // Borrow-in maps to an inverted initial carry for ten's complement
                    carry_d = i_mode ? ~i_carry : i_carry;
                    res_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                res_d[4*idx_q +: 4] = sum_dig;
                carry_d             = dig_carry;
                if (finish) begin
                    state_d  = StDone;
                    num_d    = res_d;
                    ocarry_d = mode_q ? ~dig_carry : dig_carry;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            num_q    <= '0;
            ocarry_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            num_q    <= num_d;
            ocarry_q <= ocarry_d;
        end
    end

`ifdef BCD_ADDSUB_INVALID_DIGIT_EN
    logic bad_digit;
    logic err_q, err_d;

    // Flag any latched operand digit above 9
    always_comb begin
        bad_digit = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((a_q[4*i +: 4] > 4'd9) || (b_q[4*i +: 4] > 4'd9)) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Error flag is refreshed only at completion
    always_comb begin
        err_d = err_q;
        if (finish) begin
            err_d = bad_digit;
        end
    end

    // Error flag register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_num   = num_q;
    assign o_carry = ocarry_q;
    assign o_busy  = (state_q == StRun);
    assign o_done  = (state_q == StDone);

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq with NUM_DIGITS=8.
module tb_bcd_addsub_seq;

    localparam int    ND  = 8;
    localparam longint MOD = 64'd100000000;
`ifdef BCD_ADDSUB_INVALID_DIGIT_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [ND*4-1:0] num_a, num_b;
    logic          cin;
    logic [ND*4-1:0] o_num;
    logic          o_carry, o_busy, o_done, o_err;

    typedef struct {
        logic [31:0] num;
        logic        carry;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    bcd_addsub_seq #(.NUM_DIGITS(ND)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_mode  (mode),
        .i_num_a (num_a),
        .i_num_b (num_b),
        .i_carry (cin),
        .o_num   (o_num),
        .o_carry (o_carry),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    function automatic longint from_bcd(input logic [31:0] v);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; optionally push the decimal-model expectation
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                            input logic c, input bit push);
        exp_t   e;
        longint av, bv, r;
        av = from_bcd(a);
        bv = from_bcd(b);
        if (!m) begin
            r = av + bv + longint'(c);
            e.carry = (r >= MOD);
            if (r >= MOD) r -= MOD;
        end else begin
            r = av - bv - longint'(c);
            e.carry = (r < 0);
            if (r < 0) r += MOD;
        end
        e.num = to_bcd(r);
        e.err = 1'b0;
        if (push) sb_q.push_back(e);
        num_a = a;
        num_b = b;
        mode  = m;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!o_done && cycles < 40);
        if (!o_done) cycles = -1;
    endtask

    task automatic pop_exp(output exp_t e);
        e.num = 32'hxxxxxxxx;
        e.carry = 1'bx;
        e.err = 1'bx;
        if (sb_q.size() > 0) e = sb_q.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 1'b0; num_a = 32'h12345678; num_b = 32'h1; cin = 1'b1;
        #3;
        n_cmp++;
        if ({o_num, o_carry, o_busy, o_done, o_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got num=%h c=%b b=%b d=%b e=%b, want all 0",
                     o_num, o_carry, o_busy, o_done, o_err);
        end
        repeat (3) tick();
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got busy=%b done=%b, want 0 0", o_busy, o_done);
        end
        start = 1'b0;
        #4 rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [31:0] ta[3] = '{32'h60000000, 32'h99999999, 32'h00004567};
        logic [31:0] tb[3] = '{32'h29999999, 32'h00000001, 32'h00005433};
        logic        tc[3] = '{1'b1, 1'b0, 1'b0};
        int cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b0, tc[i], 1'b1);
            n_cmp++;
            if (o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL add_busy[%0d]: got %b, want 1", i, o_busy);
            end
            wait_done(cyc);
            pop_exp(e);
            n_cmp++;
            if (cyc !== ND) begin
                n_fail++;
                $display("FAIL add_latency[%0d]: got %0d edges, want %0d", i, cyc, ND);
            end
            n_cmp++;
            if (o_num !== e.num || o_carry !== e.carry || o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL add_result[%0d]: got %h c=%b e=%b, want %h c=%b e=0",
                         i, o_num, o_carry, o_err, e.num, e.carry);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] ta[3] = '{32'h00000005, 32'h12345678, 32'h50000000};
        logic [31:0] tb[3] = '{32'h00000007, 32'h00345678, 32'h49999999};
        logic        tc[3] = '{1'b0, 1'b0, 1'b1};
        int cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], 1'b1, tc[i], 1'b1);
            wait_done(cyc);
            pop_exp(e);
            n_cmp++;
            if (cyc !== ND || o_num !== e.num || o_carry !== e.carry) begin
                n_fail++;
                $display("FAIL sub_result[%0d]: got %h c=%b after %0d edges, want %h c=%b after %0d",
                         i, o_num, o_carry, cyc, e.num, e.carry, ND);
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            start_op(to_bcd(longint'($urandom_range(0, 99999999))),
                     to_bcd(longint'($urandom_range(0, 99999999))),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            wait_done(cyc);
            pop_exp(e);
            n_cmp++;
            if (cyc !== ND || o_num !== e.num || o_carry !== e.carry) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h c=%b after %0d edges, want %h c=%b",
                         i, o_num, o_carry, cyc, e.num, e.carry);
            end
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        exp_t e;
        start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        // Second start mid-run with different operands; inputs stay changed afterwards
        start = 1'b1; num_a = 32'h99999999; num_b = 32'h99999999; mode = 1'b1; cin = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy: got %b, want 1", o_busy);
        end
        wait_done(cyc);
        pop_exp(e);
        n_cmp++;
        if (cyc + 3 !== ND) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d edges, want %0d", cyc + 3, ND);
        end
        n_cmp++;
        if (o_num !== e.num || o_carry !== e.carry) begin
            n_fail++;
            $display("FAIL ignore_result: got %h c=%b, want %h c=%b", o_num, o_carry, e.num, e.carry);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        exp_t e;
        logic [31:0] prev;
        prev = o_num;
        // Called while o_done is high: start is held through the DONE cycle
        start_op(32'h87654321, 32'h12345678, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got busy=%b done=%b, want 1 0", o_busy, o_done);
        end
        n_cmp++;
        if (o_num !== prev) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h while busy, want %h", o_num, prev);
        end
        wait_done(cyc);
        pop_exp(e);
        n_cmp++;
        if (cyc !== ND || o_num !== e.num || o_carry !== e.carry) begin
            n_fail++;
            $display("FAIL b2b_result: got %h c=%b after %0d edges, want %h c=%b",
                     o_num, o_carry, cyc, e.num, e.carry);
        end
        tick();
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b, want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int dones;
        exp_t e;
        start_op(32'h45454545, 32'h10101010, 1'b0, 1'b0, 1'b1);
        void'(sb_q.pop_back());
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_num, o_carry, o_busy, o_done, o_err} !== '0) begin
            n_fail++;
            $display("FAIL abort_async: got num=%h c=%b b=%b d=%b e=%b, want all 0",
                     o_num, o_carry, o_busy, o_done, o_err);
        end
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_done) dones++;
        end
        n_cmp++;
        if (dones !== 0 || o_num !== '0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done pulses num=%h, want 0 and 0", dones, o_num);
        end
        start_op(32'h00000999, 32'h00000001, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        pop_exp(e);
        n_cmp++;
        if (cyc !== ND || o_num !== e.num || o_carry !== e.carry) begin
            n_fail++;
            $display("FAIL after_abort: got %h c=%b after %0d edges, want %h c=%b",
                     o_num, o_carry, cyc, e.num, e.carry);
        end
    endtask

    task automatic test_invalid();
        int cyc;
        exp_t e;
        start_op(32'h0000000A, 32'h00000000, 1'b0, 1'b0, 1'b0);
        // 0xA + 0 exceeds 9: +6 gives digit 0 with a carry into digit 1
        e.num = 32'h00000010; e.carry = 1'b0; e.err = ERR_EXP;
        sb_q.push_back(e);
        wait_done(cyc);
        pop_exp(e);
        n_cmp++;
        if (o_num !== e.num || o_carry !== e.carry) begin
            n_fail++;
            $display("FAIL invalid_result: got %h c=%b, want %h c=%b", o_num, o_carry, e.num, e.carry);
        end
        n_cmp++;
        if (o_err !== e.err) begin
            n_fail++;
            $display("FAIL invalid_err: got %b, want %b", o_err, e.err);
        end
        start_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        pop_exp(e);
        n_cmp++;
        if (o_err !== 1'b0 || o_num !== e.num) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b num=%h, want err=0 num=%h", o_err, o_num, e.num);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_invalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/bcd_addsub_seq.md
BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the operand width in BCD digits; legal range is 1..32.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port i_mode, input, 1 bit: 0 = add, 1 = subtract.
REQ-006 The block SHALL have port i_num_a, input, NUM_DIGITS*4 bits: operand A, packed BCD with the least significant digit in bits [3:0].
REQ-007 The block SHALL have port i_num_b, input, NUM_DIGITS*4 bits: operand B, packed BCD in the same digit order as A.
REQ-008 The block SHALL have port i_carry, input, 1 bit: carry-in in add mode, borrow-in in subtract mode.
REQ-009 The block SHALL have port o_num, output, NUM_DIGITS*4 bits: result, packed BCD.
REQ-010 The block SHALL have port o_carry, output, 1 bit: carry-out in add mode, borrow-out in subtract mode.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high while an operation is in progress.
REQ-012 The block SHALL have port o_done, output, 1 bit: one-cycle pulse marking that o_num and o_carry are valid.
REQ-013 The block SHALL have port o_err, output, 1 bit: invalid-digit flag (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 At a rising edge with the FSM in IDLE or DONE, i_start=1 SHALL be accepted. Acceptance latches i_num_a, i_num_b, i_mode and i_carry, sets the digit index to 0 and moves the FSM to RUN.
REQ-016 i_start SHALL be ignored while the FSM is in RUN; latched operands and progress are not affected.
REQ-017 In RUN, one digit SHALL be processed per edge, least significant digit first. Processing a digit writes that result digit and updates the internal carry.
REQ-018 After the edge that processes digit NUM_DIGITS-1, the FSM SHALL go to DONE.
REQ-019 Latency: for a start accepted at edge E, the FSM SHALL be in DONE with o_done=1 from edge E+NUM_DIGITS until the next edge.
REQ-020 From DONE, the FSM SHALL go to IDLE at the next edge if i_start=0, and to RUN if i_start=1. A start accepted in DONE does not shorten the o_done pulse.
REQ-021 o_busy SHALL be 1 exactly when the FSM is in RUN.
REQ-022 Add mode: the result SHALL be A + B + i_carry, taken modulo 10^NUM_DIGITS. o_carry is 1 when the true sum is at least 10^NUM_DIGITS.
REQ-023 Subtract mode: the result SHALL be computed as A + (nines' complement of B) + (1 - i_carry), taken modulo 10^NUM_DIGITS. A negative result therefore appears in ten's complement. o_carry is the inverse of the final internal carry, i.e. it equals 1 when A < B + i_carry.
REQ-024 Per-digit step: the raw 5-bit sum is a_digit + b_operand_digit + carry. If the raw sum exceeds 9, 6 SHALL be added to it, the low 4 bits are taken as the result digit, and the carry out is 1; otherwise the carry out is 0.
REQ-025 o_num and o_carry SHALL be updated only when an operation completes (entry into DONE). They hold their values until the next completion.
REQ-026 Input changes after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-027 While i_rst=1, regardless of i_clk, the FSM SHALL be in IDLE and all outputs SHALL be 0: o_num=0, o_carry=0, o_busy=0, o_done=0, o_err=0. The digit index and the latched operands SHALL also be cleared.
REQ-028 Asserting i_rst during RUN SHALL abort the operation: no o_done pulse is produced and o_num stays 0.
REQ-029 The first accepted start after i_rst is deasserted SHALL behave per REQ-015 to REQ-019.

Configuration
REQ-030 Macro BCD_ADDSUB_INVALID_DIGIT_EN SHALL control invalid-digit detection.
- When defined: o_err is set at entry into DONE if any latched digit of A or B exceeds 9. o_err holds until the next completion or reset. Results for such inputs are still produced per REQ-024.
- When not defined: o_err is tied to 0, and no detection logic is synthesised.

Verification (NUM_DIGITS=8)
REQ-031 Add, A=60000000, B=29999999, i_carry=1 -> o_num=90000000, o_carry=0, o_done high exactly 8 edges after acceptance.
REQ-032 Add wrap-around, A=99999999, B=00000001, i_carry=0 -> o_num=00000000, o_carry=1.
REQ-033 Subtract, A=00000005, B=00000007, i_carry=0 -> o_num=99999998, o_carry=1. Then A=12345678, B=00345678, i_carry=0 -> o_num=12000000, o_carry=0.
REQ-034 Start an add of 11111111+22222222, pulse i_start again at cycle 3 with different operands -> second start ignored, o_num=33333333. Then hold i_start=1 in the DONE cycle -> o_busy=1 on the next cycle with no gap.
REQ-035 Assert i_rst at cycle 4 of RUN -> outputs drop to 0 immediately (asynchronously), no o_done pulse follows, and the next operation completes correctly.
REQ-036 With BCD_ADDSUB_INVALID_DIGIT_EN defined, add A=0000000A, B=00000000 -> o_err=1 at o_done. With the macro undefined -> o_err stays 0.
